// File: rtl/router_pkg.sv
// Shared router definitions: flit type encodings, packet framing states and
// the credit-count width helper.
package router_pkg;

    localparam logic [2:0] FLIT_TYPE_HEADER = 3'b001;
    localparam logic [2:0] FLIT_TYPE_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TYPE_TAIL   = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } pkt_state_t;

    function automatic int credit_width(input int credit_max);
        return $clog2(credit_max + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream free-slot counter: decrements on an accepted send, increments on
// a returned credit, saturates at CREDIT_MAX and reports misuse as pulses.
module credit_counter
    import router_pkg::*;
#(
    parameter  int CREDIT_MAX = 3,
    localparam int CW         = credit_width(CREDIT_MAX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec_req,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          overflow_pulse,
    output logic          underflow_attempt_pulse
);

    localparam logic [CW-1:0] COUNT_MAX = CW'(CREDIT_MAX);

    logic dec;
    logic at_max;

    // A decrement request at zero is refused; a credit arriving in that same
    // cycle still lands, so the count rises to 1 without being bypassed.
    assign nonzero                 = (count != '0);
    assign dec                     = dec_req & nonzero;
    assign at_max                  = (count == COUNT_MAX);
    assign overflow_pulse          = inc & ~dec & at_max;
    assign underflow_attempt_pulse = dec_req & ~nonzero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= COUNT_MAX;
        end else if (inc && !dec && !at_max) begin
            count <= count + 1'b1;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/flit_sender_credit_based.sv
// Output-port transmit stage: registers granted flits onto the link when a
// downstream credit exists, and checks header/body/tail framing.
module flit_sender_credit_based
    import router_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int CREDIT_MAX = 3,
    localparam int CW         = credit_width(CREDIT_MAX)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] flit_in,
    input  logic                  grant_in,
    input  logic                  credit_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] TX,
    output logic                  valid_out,
    output logic [CW-1:0]         credit_count_out,
    output logic                  err_no_credit,
    output logic                  err_credit_overflow,
    output logic                  err_protocol,
    output pkt_state_t            pkt_state_dbg
);

    // Link handshake: a flit is transferred in every cycle valid_out is high;
    // there is no ready back-pressure, the credit count is the flow control.

    logic       send;
    logic       nonzero;
    logic       overflow_pulse;
    logic       underflow_attempt_pulse;
    logic [2:0] flit_type;
    logic       proto_err;
    pkt_state_t state_q;
    pkt_state_t state_d;

    credit_counter #(
        .CREDIT_MAX (CREDIT_MAX)
    ) u_credit_counter (
        .clk                     (clk),
        .reset                   (reset),
        .inc                     (credit_in),
        .dec_req                 (grant_in),
        .count                   (credit_count_out),
        .nonzero                 (nonzero),
        .overflow_pulse          (overflow_pulse),
        .underflow_attempt_pulse (underflow_attempt_pulse)
    );

    assign ready_out     = nonzero;
    assign send          = grant_in & nonzero;
    assign flit_type     = flit_in[DATA_WIDTH-1 -: 3];
    assign pkt_state_dbg = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Framing only advances on flits that actually leave; offending flits are
    // still transmitted and merely flagged.
    always_comb begin
        state_d   = state_q;
        proto_err = 1'b0;
        if (send) begin
            case (state_q)
                IDLE: begin
                    if (flit_type == FLIT_TYPE_HEADER) begin
                        state_d = BODY;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
                BODY: begin
                    if (flit_type == FLIT_TYPE_TAIL) begin
                        state_d = IDLE;
                    end else if (flit_type != FLIT_TYPE_BODY) begin
                        proto_err = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            TX                  <= '0;
            valid_out           <= 1'b0;
            err_no_credit       <= 1'b0;
            err_credit_overflow <= 1'b0;
            err_protocol        <= 1'b0;
        end else begin
            valid_out           <= send;
            if (send) begin
                TX <= flit_in;
            end
            err_no_credit       <= err_no_credit | underflow_attempt_pulse;
            err_credit_overflow <= err_credit_overflow | overflow_pulse;
            err_protocol        <= err_protocol | proto_err;
        end
    end

endmodule

// File: tb/tb_flit_sender_credit_based.sv
// Directed bench for flit_sender_credit_based with a transmitted-flit
// scoreboard and a small reference model of credits, framing and error flags.
module tb_flit_sender_credit_based;
    import router_pkg::*;

    localparam int DW = 32;
    localparam int CM = 3;
    localparam int CW = 2;

    localparam logic [DW-1:0] H_FLIT = 32'h2000_0001;
    localparam logic [DW-1:0] T_FLIT = 32'h8000_0003;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] flit_in;
    logic          grant_in;
    logic          credit_in;
    logic          ready_out;
    logic [DW-1:0] TX;
    logic          valid_out;
    logic [CW-1:0] credit_count_out;
    logic          err_no_credit;
    logic          err_credit_overflow;
    logic          err_protocol;
    pkt_state_t    pkt_state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    int   m_cnt;
    logic m_nc;
    logic m_ov;
    logic m_pe;
    logic m_state;
    logic m_valid;

    flit_sender_credit_based #(
        .DATA_WIDTH (DW),
        .CREDIT_MAX (CM)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .flit_in             (flit_in),
        .grant_in            (grant_in),
        .credit_in           (credit_in),
        .ready_out           (ready_out),
        .TX                  (TX),
        .valid_out           (valid_out),
        .credit_count_out    (credit_count_out),
        .err_no_credit       (err_no_credit),
        .err_credit_overflow (err_credit_overflow),
        .err_protocol        (err_protocol),
        .pkt_state_dbg       (pkt_state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count"},    32'(credit_count_out),    32'(m_cnt));
        check({tag, "_valid"},    32'(valid_out),           32'(m_valid));
        check({tag, "_no_credit"}, 32'(err_no_credit),      32'(m_nc));
        check({tag, "_overflow"}, 32'(err_credit_overflow), 32'(m_ov));
        check({tag, "_protocol"}, 32'(err_protocol),        32'(m_pe));
        check({tag, "_state"},    32'(pkt_state_dbg),       32'(m_state));
    endtask

    task automatic model_reset();
        m_cnt   = CM;
        m_nc    = 1'b0;
        m_ov    = 1'b0;
        m_pe    = 1'b0;
        m_state = 1'b0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    // driver: one clock cycle of stimulus, model update and post-edge checks
    task automatic cycle(input string tag, input logic g, input logic [DW-1:0] f, input logic c);
        logic       snd;
        logic [2:0] ft;
        grant_in  = g;
        flit_in   = f;
        credit_in = c;
        #1;
        check({tag, "_ready"}, 32'(ready_out), 32'(m_cnt != 0));
        snd = g && (m_cnt != 0);
        if (g && m_cnt == 0) m_nc = 1'b1;
        if (c && !snd && m_cnt == CM) m_ov = 1'b1;
        if (snd) begin
            exp_q.push_back(f);
            ft = f[DW-1 -: 3];
            if (!m_state) begin
                if (ft == 3'b001) m_state = 1'b1;
                else m_pe = 1'b1;
            end else begin
                if (ft == 3'b100) m_state = 1'b0;
                else if (ft != 3'b010) m_pe = 1'b1;
            end
        end
        if (snd && !c) m_cnt = m_cnt - 1;
        else if (c && !snd && m_cnt < CM) m_cnt = m_cnt + 1;
        m_valid = snd;
        @(posedge clk);
        #1;
        grant_in  = 1'b0;
        credit_in = 1'b0;
        check_all(tag);
    endtask

    function automatic logic [DW-1:0] body_flit();
        logic [28:0] payload;
        payload = 29'($urandom_range(0, 32'h1fff_ffff));
        return {3'b010, payload};
    endfunction

    // scoreboard: every link transfer must match the oldest flit sent
    always @(negedge clk) begin
        if (reset === 1'b1 && valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("tx_unexpected", 32'(valid_out), 32'd0);
            end else begin
                check("tx_data", TX, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b0;
        grant_in  = 1'b0;
        credit_in = 1'b0;
        flit_in   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_tx", TX, '0);
        check("reset_ready", 32'(ready_out), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("idle");

        // drain all credits, fourth grant is refused
        cycle("t2_hdr", 1'b1, H_FLIT, 1'b0);
        cycle("t2_body0", 1'b1, body_flit(), 1'b0);
        cycle("t2_body1", 1'b1, body_flit(), 1'b0);
        cycle("t2_tail_refused", 1'b1, T_FLIT, 1'b0);
        check("t2_no_credit_set", 32'(err_no_credit), 32'd1);

        // zero credit, grant together with a returning credit
        cycle("t3_grant_and_credit", 1'b1, T_FLIT, 1'b1);
        cycle("t3_tail", 1'b1, T_FLIT, 1'b0);
        check("t3_state_idle", 32'(pkt_state_dbg), 32'(IDLE));

        // send and credit in the same cycle
        cycle("t4_credit0", 1'b0, '0, 1'b1);
        cycle("t4_credit1", 1'b0, '0, 1'b1);
        cycle("t4_hdr_with_credit", 1'b1, H_FLIT, 1'b1);
        cycle("t4_tail_with_credit", 1'b1, T_FLIT, 1'b1);

        // overflow at full count, flag stays set
        cycle("t5_credit_fill", 1'b0, '0, 1'b1);
        cycle("t5_credit_over", 1'b0, '0, 1'b1);
        cycle("t5_sticky", 1'b0, '0, 1'b0);
        check("t5_overflow_set", 32'(err_credit_overflow), 32'd1);

        // framing: body in IDLE is flagged but transmitted, then a clean packet
        cycle("t6_body_in_idle", 1'b1, body_flit(), 1'b0);
        check("t6_protocol_set", 32'(err_protocol), 32'd1);
        cycle("t6_credit", 1'b0, '0, 1'b1);
        cycle("t6_hdr", 1'b1, H_FLIT, 1'b0);
        cycle("t6_body", 1'b1, body_flit(), 1'b1);
        cycle("t6_tail", 1'b1, T_FLIT, 1'b1);

        // asynchronous reset mid-packet
        cycle("t7_hdr", 1'b1, H_FLIT, 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        check_all("t7_async_reset");
        check("t7_reset_tx", TX, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // illegal type code in IDLE
        cycle("t8_illegal", 1'b1, 32'h0000_0005, 1'b0);
        cycle("t8_illegal_body", 1'b1, 32'hE000_0006, 1'b1);
        cycle("t8_drain", 1'b0, '0, 1'b0);
        cycle("t8_idle", 1'b0, '0, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flit_sender_credit_based.md
Name: flit_sender_credit_based

Overview:
- Transmit stage of one router output port; sits directly upstream of the neighbour router's credit-based input FIFO.
- Registers crossbar flits onto the link (TX/valid_out) only when a downstream credit is available.
- Tracks downstream free slots via returned credit pulses.
- Checks header/body/tail packet framing and raises sticky error flags for link debug.

Parameters:
- DATA_WIDTH, 32, flit width; bits [DATA_WIDTH-1:DATA_WIDTH-3] carry the flit type.
- CREDIT_MAX, 3, usable slots in the downstream FIFO (4-entry one-hot ring, one slot always empty).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flit_in  in  DATA_WIDTH  flit from crossbar for this output port.
- grant_in  in  1  allocator grant; a flit is offered this cycle.
- credit_in  in  1  one-cycle pulse from the downstream FIFO: one slot freed.
- ready_out  out  1  combinational; credit_count != 0.
- TX  out  DATA_WIDTH  registered link data.
- valid_out  out  1  registered link valid; drives the neighbour's valid_in.
- credit_count_out  out  $clog2(CREDIT_MAX+1)  current credit count.
- err_no_credit  out  1  sticky; grant_in seen while credit_count == 0.
- err_credit_overflow  out  1  sticky; credit_in would exceed CREDIT_MAX.
- err_protocol  out  1  sticky; flit type illegal for the current packet state.

Behaviour:
- Reset (async, active-low):
  - credit_count = CREDIT_MAX; TX = 0; valid_out = 0.
  - All error flags = 0; FSM = IDLE.
  - Reset asserted mid-packet discards the state immediately. No flush; the link partner is reset together with this block.
- send = grant_in & (credit_count != 0).
- Latency is 1 cycle. On send, TX <= flit_in and valid_out <= 1 at the next edge. Otherwise valid_out <= 0 and TX holds its last value.
- Credit counter next value:
  - send only: count - 1.
  - credit_in only: count + 1.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
- Boundary, count == 0 with grant_in:
  - No flit is sent; valid_out <= 0 and the count stays 0.
  - err_no_credit <= 1.
  - A simultaneous credit_in still increments the count to 1. That credit is usable from the next cycle only; ready_out is never bypassed.
- Boundary, count == CREDIT_MAX with credit_in and no send:
  - Count saturates at CREDIT_MAX.
  - err_credit_overflow <= 1.
- Flit type field (top 3 bits): 001 header, 010 body, 100 tail. Any other code is illegal.
- Packet FSM advances only on send:
  - IDLE + header -> BODY.
  - BODY + body -> BODY.
  - BODY + tail -> IDLE.
  - IDLE + body or tail: err_protocol, stay IDLE.
  - BODY + header: err_protocol, stay BODY.
  - Illegal type in either state: err_protocol, state unchanged.
- Flits that cause a protocol error are still transmitted; the checker never blocks traffic.
- Error flags are cleared only by reset.

Decomposition:
- Shared package router_pkg:
  - FLIT_TYPE_HEADER = 3'b001, FLIT_TYPE_BODY = 3'b010, FLIT_TYPE_TAIL = 3'b100.
  - pkt_state_t enum {IDLE, BODY}.
  - Credit-count width function $clog2(CREDIT_MAX+1).
- One sub-module, credit_counter.
  - Inputs: inc, dec, reset value CREDIT_MAX.
  - Outputs: count, nonzero, overflow_pulse, underflow_attempt_pulse.
- Framing FSM and output register stay in the top module.

Test Plan:
1. Reset released, no traffic -> credit_count_out = 3, ready_out = 1, valid_out = 0, TX = 0, all errors 0.
2. Grant 4 consecutive cycles with no credits; flits header (0x2000_0001), body, body, tail ->
   - First 3 appear on TX one cycle later with valid_out = 1.
   - Count steps 3→2→1→0.
   - 4th grant: valid_out = 0 and err_no_credit = 1.
3. Count = 0, then a credit_in pulse -> count = 1 and ready_out = 1 next cycle; the tail is then sent and the FSM returns to IDLE.
4. Count = 2, send and credit_in in the same cycle -> count stays 2 and valid_out = 1 next cycle.
5. Count = 3, credit_in pulse with no send -> count stays 3 and err_credit_overflow = 1 (sticky).
6. Body flit sent in IDLE -> flit still on TX with valid_out = 1 and err_protocol = 1. Then header, body, tail sent: no further change to the flags, and the FSM sequence is IDLE→BODY→BODY→IDLE.
